// File: rtl/cpu_defs.sv
// Shared CPU-wide definitions: RoB index width, the no-dependency tag and
// the CDB source encodings.
package cpu_defs;
  localparam int unsigned RoB_WIDTH = 8;
  localparam logic [RoB_WIDTH-1:0] NON_DEP = '1;
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-push and broadcast signals of the common-data-bus arbiter.
// master = producers/snoopers side, slave = the arbiter itself.
interface cdb_arbiter_if #(
  parameter int unsigned RoB_WIDTH = cpu_defs::RoB_WIDTH
);
  logic                 RoBCA_pre_judge;
  logic                 ALUCA_en;
  logic [RoB_WIDTH-1:0] ALUCA_RoB_index;
  logic [31:0]          ALUCA_value;
  logic                 CAALU_full;
  logic                 LSBCA_en;
  logic [RoB_WIDTH-1:0] LSBCA_RoB_index;
  logic [31:0]          LSBCA_value;
  logic                 CALSB_full;
  logic                 CDB_en;
  logic [RoB_WIDTH-1:0] CDB_RoB_index;
  logic [31:0]          CDB_value;
  logic                 CDB_src;

  modport master (
    output RoBCA_pre_judge,
    output ALUCA_en, ALUCA_RoB_index, ALUCA_value,
    output LSBCA_en, LSBCA_RoB_index, LSBCA_value,
    input  CAALU_full, CALSB_full,
    input  CDB_en, CDB_RoB_index, CDB_value, CDB_src
  );

  modport slave (
    input  RoBCA_pre_judge,
    input  ALUCA_en, ALUCA_RoB_index, ALUCA_value,
    input  LSBCA_en, LSBCA_RoB_index, LSBCA_value,
    output CAALU_full, CALSB_full,
    output CDB_en, CDB_RoB_index, CDB_value, CDB_src
  );
endinterface

// File: rtl/cdb_queue.sv
// Circular result FIFO for one CDB producer; flush empties it synchronously,
// rdy low freezes it, pushes while full are dropped.
module cdb_queue #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  logic [PTR-1:0]   head_q, head_d;
  logic [PTR-1:0]   tail_q, tail_d;
  logic [PTR:0]     count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full      = (count_q == (PTR+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];

  always_comb begin
    do_push = rdy && push && !full;
    do_pop  = rdy && pop && !empty;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (do_pop) head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter draining the ALU and LSB result queues onto one
// registered broadcast bus. Define CDB_BYPASS_EN for same-edge bypass of idle pushes.
module cdb_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned RoB_WIDTH = cpu_defs::RoB_WIDTH,
  parameter int unsigned Q_DEPTH   = 4,
  parameter int unsigned Q_PTR     = 2
) (
  input  logic         Sys_clk,
  input  logic         Sys_rst,
  input  logic         Sys_rdy,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned EW = RoB_WIDTH + 32;

  logic                 flush;
  logic                 alu_full, alu_empty, lsb_full, lsb_empty;
  logic [EW-1:0]        alu_head, lsb_head;
  logic                 alu_push, lsb_push, alu_pop, lsb_pop;
  logic                 grant_vld, grant_src;
  logic                 byp_vld, byp_src;

  logic                 cdb_en_q, cdb_en_d;
  logic [RoB_WIDTH-1:0] cdb_idx_q, cdb_idx_d;
  logic [31:0]          cdb_val_q, cdb_val_d;
  logic                 cdb_src_q, cdb_src_d;
  logic                 last_grant_q, last_grant_d;

  assign flush = !bus.RoBCA_pre_judge;

  // Both nonempty: alternate away from the last grant; otherwise the lone nonempty queue.
  always_comb begin
    grant_vld = !alu_empty || !lsb_empty;
    if (!alu_empty && !lsb_empty) grant_src = ~last_grant_q;
    else                          grant_src = !lsb_empty ? CDB_SRC_LSB : CDB_SRC_ALU;
    alu_pop = grant_vld && (grant_src == CDB_SRC_ALU);
    lsb_pop = grant_vld && (grant_src == CDB_SRC_LSB);
  end

`ifdef CDB_BYPASS_EN
  logic byp_alu_ok, byp_lsb_ok;
  always_comb begin
    byp_alu_ok = bus.ALUCA_en && alu_empty && !grant_vld;
    byp_lsb_ok = bus.LSBCA_en && lsb_empty && !grant_vld;
    byp_vld    = byp_alu_ok || byp_lsb_ok;
    if (byp_alu_ok && byp_lsb_ok) byp_src = ~last_grant_q;
    else                          byp_src = byp_lsb_ok ? CDB_SRC_LSB : CDB_SRC_ALU;
  end
`else
  assign byp_vld = 1'b0;
  assign byp_src = CDB_SRC_ALU;
`endif

  assign alu_push = bus.ALUCA_en && !(byp_vld && (byp_src == CDB_SRC_ALU));
  assign lsb_push = bus.LSBCA_en && !(byp_vld && (byp_src == CDB_SRC_LSB));

  cdb_queue #(.WIDTH(EW), .DEPTH(Q_DEPTH), .PTR(Q_PTR)) u_alu_q (
    .clk       (Sys_clk),
    .rst       (Sys_rst),
    .rdy       (Sys_rdy),
    .flush     (flush),
    .push      (alu_push),
    .push_data ({bus.ALUCA_RoB_index, bus.ALUCA_value}),
    .pop       (alu_pop),
    .head_data (alu_head),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  cdb_queue #(.WIDTH(EW), .DEPTH(Q_DEPTH), .PTR(Q_PTR)) u_lsb_q (
    .clk       (Sys_clk),
    .rst       (Sys_rst),
    .rdy       (Sys_rdy),
    .flush     (flush),
    .push      (lsb_push),
    .push_data ({bus.LSBCA_RoB_index, bus.LSBCA_value}),
    .pop       (lsb_pop),
    .head_data (lsb_head),
    .full      (lsb_full),
    .empty     (lsb_empty)
  );

  always_comb begin
    cdb_en_d     = cdb_en_q;
    cdb_idx_d    = cdb_idx_q;
    cdb_val_d    = cdb_val_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      cdb_en_d     = 1'b0;
      last_grant_d = CDB_SRC_LSB;
    end else if (Sys_rdy) begin
      if (grant_vld) begin
        cdb_en_d                 = 1'b1;
        cdb_src_d                = grant_src;
        {cdb_idx_d, cdb_val_d}   = (grant_src == CDB_SRC_LSB) ? lsb_head : alu_head;
        last_grant_d             = grant_src;
      end else if (byp_vld) begin
        cdb_en_d                 = 1'b1;
        cdb_src_d                = byp_src;
        {cdb_idx_d, cdb_val_d}   = (byp_src == CDB_SRC_LSB)
                                   ? {bus.LSBCA_RoB_index, bus.LSBCA_value}
                                   : {bus.ALUCA_RoB_index, bus.ALUCA_value};
        last_grant_d             = byp_src;
      end else begin
        cdb_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      cdb_en_q     <= 1'b0;
      cdb_idx_q    <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= CDB_SRC_ALU;
      last_grant_q <= CDB_SRC_LSB;
    end else begin
      cdb_en_q     <= cdb_en_d;
      cdb_idx_q    <= cdb_idx_d;
      cdb_val_q    <= cdb_val_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.CDB_en        = cdb_en_q;
  assign bus.CDB_RoB_index = cdb_idx_q;
  assign bus.CDB_value     = cdb_val_q;
  assign bus.CDB_src       = cdb_src_q;
  assign bus.CAALU_full    = alu_full;
  assign bus.CALSB_full    = lsb_full;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, alternation, queue-full
// gating, flush and Sys_rdy stall scenarios.
module tb_cdb_arbiter;
  localparam int unsigned RW = 8;

  logic clk;
  logic rst;
  logic rdy;
  int   vecs;
  int   errs;

  cdb_arbiter_if #(.RoB_WIDTH(RW)) bus ();

  cdb_arbiter #(.RoB_WIDTH(RW), .Q_DEPTH(4), .Q_PTR(2)) dut (
    .Sys_clk (clk),
    .Sys_rst (rst),
    .Sys_rdy (rdy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Item i of a source: ALU idx 0x10+i / val A000_000i, LSB idx 0x20+i / val B000_000i.
  function automatic logic [RW+31:0] exp_item(input logic src, input int i);
    logic [RW-1:0] idx;
    logic [31:0]   v;
    idx = src ? RW'(32'h20 + i) : RW'(32'h10 + i);
    v   = src ? (32'hB000_0000 + 32'(i)) : (32'hA000_0000 + 32'(i));
    return {idx, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_en, input int ai, input logic l_en, input int li);
    bus.ALUCA_en = a_en;
    {bus.ALUCA_RoB_index, bus.ALUCA_value} = exp_item(1'b0, ai);
    bus.LSBCA_en = l_en;
    {bus.LSBCA_RoB_index, bus.LSBCA_value} = exp_item(1'b1, li);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    bus.RoBCA_pre_judge = 1'b1;
    drive(1'b0, 0, 1'b0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src} !== '0) begin
      errs++;
      $display("FAIL reset_cdb: got en=%b idx=%h val=%h src=%b, expected all zero",
               bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      vecs++;
      if ({bus.CDB_en, bus.CAALU_full, bus.CALSB_full} !== 3'b000) begin
        errs++;
        $display("FAIL reset_idle[%0d]: got en=%b alu_full=%b lsb_full=%b, expected 0 0 0",
                 c, bus.CDB_en, bus.CAALU_full, bus.CALSB_full);
      end
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    drive(1'b1, 0, 1'b0, 0);
    bus.ALUCA_RoB_index = 8'd3;
    bus.ALUCA_value     = 32'h11;
    tick();
    drive(1'b0, 0, 1'b0, 0);
`ifndef CDB_BYPASS_EN
    vecs++;
    if (bus.CDB_en !== 1'b0) begin
      errs++;
      $display("FAIL single_edge1: got en=%b, expected 0", bus.CDB_en);
    end
    tick();
`endif
    vecs++;
    if ({bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src} !== {1'b1, 8'd3, 32'h11, 1'b0}) begin
      errs++;
      $display("FAIL single_bcast: got en=%b idx=%h val=%h src=%b, expected en=1 idx=03 val=00000011 src=0",
               bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src);
    end
    tick();
    vecs++;
    if (bus.CDB_en !== 1'b0) begin
      errs++;
      $display("FAIL single_once: got en=%b, expected 0", bus.CDB_en);
    end
  endtask

  task automatic test_alternate();
    int k;
    logic es;
    logic [RW+31:0] e;
    do_reset();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 3) drive(1'b1, c, 1'b1, c);
      else       drive(1'b0, 0, 1'b0, 0);
      tick();
      if (bus.CDB_en === 1'b1) begin
        es = (k % 2) != 0;
        e  = exp_item(es, k / 2);
        vecs++;
        if (k >= 6 || {bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value} !== {es, e}) begin
          errs++;
          $display("FAIL alt_bcast[%0d]: got src=%b idx=%h val=%h, expected src=%b idx=%h val=%h (of 6)",
                   k, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value, es, e[RW+31:32], e[31:0]);
        end
        k++;
      end
    end
    vecs++;
    if (k !== 6) begin
      errs++;
      $display("FAIL alt_count: got %0d broadcasts, expected 6", k);
    end
  endtask

  task automatic test_back_to_back();
    int k, na, nl, rise;
    logic ap, lp, es, full7;
    logic [RW+31:0] e;
    do_reset();
    k = 0; na = 0; nl = 0; rise = -1; full7 = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      ap = (na < 8) && !bus.CAALU_full;
      lp = (nl < 8) && !bus.CALSB_full;
      drive(ap, na, lp, nl);
      tick();
      if (ap) na++;
      if (lp) nl++;
      if (bus.CALSB_full === 1'b1 && rise < 0) rise = c;
      if (c == 7) full7 = bus.CALSB_full;
      if (bus.CDB_en === 1'b1) begin
        es = (k % 2) != 0;
        e  = exp_item(es, k / 2);
        vecs++;
        if (k >= 16 || {bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value} !== {es, e}) begin
          errs++;
          $display("FAIL b2b_bcast[%0d]: got src=%b idx=%h val=%h, expected src=%b idx=%h val=%h (of 16)",
                   k, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value, es, e[RW+31:32], e[31:0]);
        end
        k++;
      end
    end
    drive(1'b0, 0, 1'b0, 0);
    vecs++;
    if (k !== 16) begin
      errs++;
      $display("FAIL b2b_count: got %0d broadcasts, expected 16", k);
    end
`ifndef CDB_BYPASS_EN
    vecs++;
    if (rise !== 6) begin
      errs++;
      $display("FAIL b2b_full_rise: got first CALSB_full at edge %0d, expected 6", rise);
    end
    vecs++;
    if (full7 !== 1'b0) begin
      errs++;
      $display("FAIL b2b_full_drop: got CALSB_full=%b after edge 7, expected 0", full7);
    end
`endif
  endtask

  task automatic test_flush();
    int na, nl, k;
    logic ap, lp, es;
    logic [RW+31:0] e;
    do_reset();
    na = 0; nl = 0;
    for (int c = 1; c <= 6; c++) begin
      ap = !bus.CAALU_full;
      lp = !bus.CALSB_full;
      drive(ap, na, lp, nl);
      tick();
      if (ap) na++;
      if (lp) nl++;
    end
    bus.RoBCA_pre_judge = 1'b0;
    drive(1'b1, 9, 1'b1, 9);
    tick();
    bus.RoBCA_pre_judge = 1'b1;
    drive(1'b0, 0, 1'b0, 0);
    vecs++;
    if ({bus.CDB_en, bus.CAALU_full, bus.CALSB_full} !== 3'b000) begin
      errs++;
      $display("FAIL flush_state: got en=%b alu_full=%b lsb_full=%b, expected 0 0 0",
               bus.CDB_en, bus.CAALU_full, bus.CALSB_full);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      vecs++;
      if (bus.CDB_en !== 1'b0) begin
        errs++;
        $display("FAIL flush_quiet[%0d]: got en=%b, expected 0", c, bus.CDB_en);
      end
    end
    // After flush last_grant points at LSB, so ALU must win the next contention.
    k = 0;
    drive(1'b1, 0, 1'b1, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      drive(1'b0, 0, 1'b0, 0);
      if (bus.CDB_en === 1'b1) begin
        es = (k % 2) != 0;
        e  = exp_item(es, 0);
        vecs++;
        if (k >= 2 || {bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value} !== {es, e}) begin
          errs++;
          $display("FAIL flush_after[%0d]: got src=%b idx=%h val=%h, expected src=%b idx=%h val=%h (of 2)",
                   k, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value, es, e[RW+31:32], e[31:0]);
        end
        k++;
      end
    end
    vecs++;
    if (k !== 2) begin
      errs++;
      $display("FAIL flush_after_count: got %0d broadcasts, expected 2", k);
    end
  endtask

  task automatic test_rdy_stall();
    int k;
    logic es, stalled;
    logic [RW+31:0] e;
    do_reset();
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      stalled = (c >= 4) && (c <= 6);
      rdy = !stalled;
      if (c <= 3)      drive(1'b1, c - 1, 1'b1, c - 1);
      else if (stalled) begin
        drive(1'b1, 0, 1'b0, 0);
        bus.ALUCA_RoB_index = 8'h7F;
        bus.ALUCA_value     = 32'hDEAD_BEEF;
      end else         drive(1'b0, 0, 1'b0, 0);
      tick();
      if (stalled) begin
        es = ((k - 1) % 2) != 0;
        e  = exp_item(es, (k - 1) / 2);
        vecs++;
        if ({bus.CDB_en, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value} !== {1'b1, es, e}) begin
          errs++;
          $display("FAIL stall_hold[%0d]: got en=%b src=%b idx=%h val=%h, expected en=1 src=%b idx=%h val=%h",
                   c, bus.CDB_en, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value, es, e[RW+31:32], e[31:0]);
        end
      end else if (bus.CDB_en === 1'b1) begin
        es = (k % 2) != 0;
        e  = exp_item(es, k / 2);
        vecs++;
        if (k >= 6 || {bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value} !== {es, e}) begin
          errs++;
          $display("FAIL stall_bcast[%0d]: got src=%b idx=%h val=%h, expected src=%b idx=%h val=%h (of 6)",
                   k, bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value, es, e[RW+31:32], e[31:0]);
        end
        k++;
      end
    end
    rdy = 1'b1;
    vecs++;
    if (k !== 6) begin
      errs++;
      $display("FAIL stall_count: got %0d broadcasts, expected 6", k);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single_alu();
    test_alternate();
    test_back_to_back();
    test_flush();
    test_rdy_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units, expected completion");
    $fatal(1);
  end
endmodule
